m_crc_engine: RTL
=================

// Module: m_crc_engine
// PURPOSE
//  Parametrised Ethernet CRC-32 engine, poly 0x04C11DB7, preset all-ones, for 4-bit (MII) or 8-bit (GMII) datapaths.
//  Accumulates the CRC over frame beats.
//  On request it emits the complemented FCS as 32/DATA_W beats with ready/valid backpressure.
//  Optionally checks the receive residue.
//  Sits between the TX/RX MAC framers and the PHY-side data path.
// PARAMETERS
//  DATA_W   4         beat width in bits; legal values 4 or 8 only
//  RESIDUE  32'hC704DD7B  Crc register value after a good frame plus its FCS
// PORTS
//  Clk         in   1       clock
//  Reset       in   1       asynchronous, active-high reset
//  Init        in   1       synchronous re-preset; aborts any activity
//  Enable      in   1       Data beat valid this cycle
//  Data        in   DATA_W  frame beat; first wire bit in Data[DATA_W-1] (caller bit-reverses MII/GMII beats)
//  FcsStart    in   1       request FCS emission after the current Crc
//  FcsReady    in   1       downstream accepts FcsData this cycle
//  CheckStrobe in   1       compare Crc against RESIDUE (end of RX frame)
//  Crc         out  32      CRC register
//  CrcNext     out  32      combinational next value for Data (valid regardless of Enable)
//  Busy        out  1       high in ACCUM or FCS
//  FcsValid    out  1       FcsData valid
//  FcsData     out  DATA_W  FCS beat, wire order (bit 0 transmitted first)
//  FcsDone     out  1       one-cycle pulse after the last FCS beat is accepted
//  CrcError    out  1       registered residue mismatch flag
// BEHAVIOUR
//  Reset values: Crc=32'hFFFFFFFF; Busy, FcsValid, FcsDone and CrcError =0; FcsData=~Crc-derived value (32'hFFFFFFFF gives 0); state IDLE.
//  LFSR definition: serial shift toward MSB, DATA_W steps per beat, Data[DATA_W-1] applied first.
//   - Per step: fb=Crc[31]^d; Crc={Crc[30:0],1'b0}^(fb?0x04C11DB7:0).
//   - For DATA_W=4 this matches the existing nibble CRC next-state equations bit-for-bit.
//   - Unrolled combinationally into CrcNext; no pipeline.
//  Latency: Crc=CrcNext the cycle after an accepted Enable beat.
//  State machine:
//   - IDLE: Enable -> ACCUM; FcsStart -> FCS.
//   - ACCUM: Enable -> absorb beat, stay; FcsStart -> FCS.
//   - FCS: FcsValid=1 for NBEAT=32/DATA_W beats.
//     - Beat counter advances only when FcsValid&FcsReady.
//     - FcsData[i]=~Crc[31-i], i=0..DATA_W-1.
//     - On accept: Crc<={Crc[31-DATA_W:0],{DATA_W{1'b1}}}.
//     - After the last accepted beat: FcsDone=1 for one cycle, Crc=32'hFFFFFFFF, -> IDLE.
//  Boundary rules:
//   - Enable and FcsStart in the same cycle: beat absorbed first, FCS emitted next cycle over the updated Crc.
//   - Enable or FcsStart while in FCS: ignored, no state change.
//   - FcsReady low: FcsData and the counter hold; no timeout.
//   - Init in any state: next cycle Crc=FFFFFFFF, state IDLE, counter 0, FcsValid/FcsDone=0. Init has priority over Enable and FcsStart.
//   - Async Reset mid-FCS: same as reset values; partial FCS is discarded.
//   - Counter width is clog2(NBEAT); wrap never occurs (exit at NBEAT-1).
// CONFIGURATION
//  CRC_RESIDUE_CHECK_EN defined:
//   - On CheckStrobe, CrcError<=(Crc!=RESIDUE) the next cycle.
//   - CrcError holds until the next CheckStrobe, Init or Reset.
//   - CheckStrobe together with Enable compares the pre-update Crc.
//  CRC_RESIDUE_CHECK_EN undefined: no comparator is built; CrcError tied 0; CheckStrobe ignored.
// TESTING
//  1 Reset, no Enable for 10 cycles -> Crc=FFFFFFFF, Busy=0, FcsValid=0.
//  2 DATA_W=8, ASCII "123456789" (0x31..0x39, bit-reversed per beat), FcsStart, FcsReady=1 ->
//    - FcsData bytes 26,39,F4,CB (bit 0 first on wire).
//    - FcsDone the cycle after the 4th beat; Crc=FFFFFFFF.
//  3 DATA_W=4, same frame as nibbles (low nibble first) ->
//    - 8 FCS nibbles 6,2,9,3,4,F,B,C.
//  4 Repeat 2 with FcsReady toggled 1,0,0,1,0,1,1 -> FcsData holds during low cycles; same 4 bytes; FcsDone exactly once.
//  5 Feed "123456789" plus its FCS 26,39,F4,CB, then CheckStrobe -> Crc=C704DD7B, CrcError=0.
//    - Corrupt one data bit -> CrcError=1 (with CRC_RESIDUE_CHECK_EN).
//  6 Init asserted on the 2nd FCS beat -> FcsValid=0 and Crc=FFFFFFFF next cycle.
//    - Then a new frame gives correct results as in 2.

Source files
------------

// File: rtl/m_crc_engine.sv
// ---------------------------------------------------------------------------
// m_crc_engine
//
// Ethernet CRC-32 engine (polynomial 0x04C11DB7, preset all-ones) for a
// 4-bit (MII) or 8-bit (GMII) beat datapath. It accumulates the CRC over
// frame beats and, when asked, streams out the complemented FCS as
// 32/DATA_W beats under ready/valid flow control. An optional receive-side
// residue check compares the CRC register against the good-frame residue.
//
// Optional feature macro: CRC_RESIDUE_CHECK_EN
//   defined   : CheckStrobe latches (Crc != RESIDUE) into CrcError
//   undefined : no comparator; CrcError is tied low, CheckStrobe ignored
//
// Parameters
//   DATA_W   beat width in bits, 4 or 8
//   RESIDUE  CRC register value after a good frame followed by its FCS
//
// Ports
//   Clk          clock
//   Reset        asynchronous active-high reset
//   Init         synchronous re-preset, aborts any activity (highest priority)
//   Enable       Data beat valid this cycle
//   Data         frame beat, first wire bit in Data[DATA_W-1]
//   FcsStart     request FCS emission over the current Crc
//   FcsReady     downstream accepts FcsData this cycle
//   CheckStrobe  compare Crc against RESIDUE (end of receive frame)
//   Crc          CRC register
//   CrcNext      combinational next CRC for Data (independent of Enable)
//   Busy         high while accumulating or emitting the FCS
//   FcsValid     FcsData valid
//   FcsData      FCS beat in wire order (bit 0 transmitted first)
//   FcsDone      one-cycle pulse after the last FCS beat is accepted
//   CrcError     registered residue mismatch flag
// ---------------------------------------------------------------------------
module m_crc_engine #(
  parameter int          DATA_W  = 4,
  parameter logic [31:0] RESIDUE = 32'hC704DD7B
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Init,
  input  logic              Enable,
  input  logic [DATA_W-1:0] Data,
  input  logic              FcsStart,
  input  logic              FcsReady,
  input  logic              CheckStrobe,
  output logic [31:0]       Crc,
  output logic [31:0]       CrcNext,
  output logic              Busy,
  output logic              FcsValid,
  output logic [DATA_W-1:0] FcsData,
  output logic              FcsDone,
  output logic              CrcError
);

  localparam int          NBEAT     = 32 / DATA_W;
  localparam int          CNT_W     = $clog2(NBEAT);
  localparam logic [31:0] POLY      = 32'h04C11DB7;
  localparam logic [31:0] PRESET    = 32'hFFFFFFFF;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEAT - 1);

  // Only MII and GMII beat widths are meaningful; anything else would also
  // leave a partial FCS beat.
  if (DATA_W != 4 && DATA_W != 8) begin : g_bad_width
    $error("m_crc_engine: DATA_W must be 4 or 8");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FCS   = 2'd2
  } state_t;

  // Serial LFSR unrolled over one beat: MSB-first shift, Data[DATA_W-1]
  // enters first. For DATA_W=4 this reproduces the classic nibble CRC
  // next-state equations exactly.
  function automatic logic [31:0] crc_step(input logic [31:0]       c,
                                           input logic [DATA_W-1:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int k = DATA_W - 1; k >= 0; k--) begin
      fb = r[31] ^ d[k];
      r  = {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    return r;
  endfunction

  // The FCS beat is the complemented top of the register, bit-reversed so
  // that FcsData[0] is the first bit on the wire.
  function automatic logic [DATA_W-1:0] fcs_beat(input logic [31:0] c);
    logic [DATA_W-1:0] b;
    b = '0;
    for (int i = 0; i < DATA_W; i++) begin
      b[i] = ~c[31-i];
    end
    return b;
  endfunction

  state_t           state_p1, state_nxt;
  logic [31:0]      crc_p1, crc_nxt;
  logic [CNT_W-1:0] cnt_p1, cnt_nxt;
  logic             done_p1, done_nxt;
  logic [31:0]      crc_upd;

  assign crc_upd = crc_step(crc_p1, Data);

  // -------- next-state / datapath select (combinational) --------
  always_comb begin
    state_nxt = state_p1;
    crc_nxt   = crc_p1;
    cnt_nxt   = cnt_p1;
    done_nxt  = 1'b0;

    if (Init) begin
      state_nxt = S_IDLE;
      crc_nxt   = PRESET;
      cnt_nxt   = '0;
    end else begin
      case (state_p1)
        S_IDLE, S_ACCUM: begin
          // A beat arriving with FcsStart is absorbed first, so the FCS
          // covers it.
          if (Enable) begin
            crc_nxt   = crc_upd;
            state_nxt = S_ACCUM;
          end
          if (FcsStart) begin
            state_nxt = S_FCS;
          end
        end

        S_FCS: begin
          // Enable/FcsStart are deliberately ignored here; only an accepted
          // beat moves the emission forward.
          if (FcsReady) begin
            if (cnt_p1 == LAST_BEAT) begin
              state_nxt = S_IDLE;
              crc_nxt   = PRESET;
              cnt_nxt   = '0;
              done_nxt  = 1'b1;
            end else begin
              // Shift the sent bits out; ones fill keeps the tail benign.
              crc_nxt = {crc_p1[31-DATA_W:0], {DATA_W{1'b1}}};
              cnt_nxt = cnt_p1 + CNT_W'(1);
            end
          end
        end

        default: begin
          state_nxt = S_IDLE;
          crc_nxt   = PRESET;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // -------- stage p1: CRC register, FSM state, beat counter --------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_p1 <= S_IDLE;
      crc_p1   <= PRESET;
      cnt_p1   <= '0;
      done_p1  <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      crc_p1   <= crc_nxt;
      cnt_p1   <= cnt_nxt;
      done_p1  <= done_nxt;
    end
  end

`ifdef CRC_RESIDUE_CHECK_EN
  logic err_p1;

  // Compares the register as it stands this cycle, so a strobe coincident
  // with Enable sees the pre-update CRC.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_p1 <= 1'b0;
    end else if (Init) begin
      err_p1 <= 1'b0;
    end else if (CheckStrobe) begin
      err_p1 <= (crc_p1 != RESIDUE);
    end
  end

  assign CrcError = err_p1;
`else
  logic unused_check;

  assign unused_check = ^{CheckStrobe, RESIDUE};
  assign CrcError     = 1'b0;
`endif

  assign Crc      = crc_p1;
  assign CrcNext  = crc_upd;
  assign Busy     = (state_p1 != S_IDLE);
  assign FcsValid = (state_p1 == S_FCS);
  assign FcsData  = fcs_beat(crc_p1);
  assign FcsDone  = done_p1;

endmodule
